// File: rtl/pixel_render_pipeline.sv
// Final render stage: fg/sprite/bg priority, palette lookup, RGB out.
// Ports: video_clk, rst, layer pixels/enables, timing in, PROM bus, RGB/timing out, collision.
module pixel_render_pipeline #(
  parameter int PAL_ADDR_W = 10,
  parameter int RGB_W = 4,
  parameter logic [PAL_ADDR_W-1:0] BACKDROP_ADDR = PAL_ADDR_W'(10'h300)
) (
  input  logic                  video_clk,
  input  logic                  rst,
  input  logic [7:0]            fg_color,
  input  logic                  fg_transparent,
  input  logic [7:0]            sprite_color,
  input  logic                  sprite_transparent,
  input  logic [7:0]            bg_color,
  input  logic                  bg_transparent,
  input  logic [2:0]            layer_enable,
  input  logic                  hsync_in,
  input  logic                  vsync_in,
  input  logic                  blank_in,
  output logic [PAL_ADDR_W-1:0] palette_read_addr,
  input  logic [3*RGB_W-1:0]    palette_read_data,
  output logic [RGB_W-1:0]      red,
  output logic [RGB_W-1:0]      green,
  output logic [RGB_W-1:0]      blue,
  output logic                  hsync_out,
  output logic                  vsync_out,
  output logic                  blank_out,
  output logic                  collision
);

  logic                  fg_op;
  logic                  sp_op;
  logic                  bg_op;
  logic [PAL_ADDR_W-1:0] sel_addr;
  // timing bundles are {hsync, vsync, blank}
  logic [2:0]            tim_d1;
  logic [2:0]            tim_d2;
  logic                  vsync_prev;
  logic                  vsync_rise;

  assign fg_op = layer_enable[0] & ~fg_transparent;
  assign sp_op = layer_enable[1] & ~sprite_transparent;
  assign bg_op = layer_enable[2] & ~bg_transparent;

  assign vsync_rise = vsync_in & ~vsync_prev;

  always_comb begin
    sel_addr = '0;
    if (fg_op) begin
      sel_addr[9:0] = {2'b00, fg_color};
    end else if (sp_op) begin
      sel_addr[9:0] = {2'b01, sprite_color};
    end else if (bg_op) begin
      sel_addr[9:0] = {2'b10, bg_color};
    end else begin
      sel_addr = BACKDROP_ADDR;
    end
  end

  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) begin
      palette_read_addr <= '0;
      tim_d1            <= 3'b001;
      tim_d2            <= 3'b001;
      red               <= '0;
      green             <= '0;
      blue              <= '0;
      hsync_out         <= 1'b0;
      vsync_out         <= 1'b0;
      blank_out         <= 1'b1;
      vsync_prev        <= 1'b0;
      collision         <= 1'b0;
    end else begin
      palette_read_addr <= sel_addr;
      tim_d1            <= {hsync_in, vsync_in, blank_in};
      tim_d2            <= tim_d1;
      {hsync_out, vsync_out, blank_out} <= tim_d2;
      if (tim_d2[0]) begin
        red   <= '0;
        green <= '0;
        blue  <= '0;
      end else begin
        red   <= palette_read_data[3*RGB_W-1 -: RGB_W];
        green <= palette_read_data[2*RGB_W-1 -: RGB_W];
        blue  <= palette_read_data[RGB_W-1:0];
      end
      vsync_prev <= vsync_in;
      // a new frame clears the flag even if this pixel overlaps
      if (vsync_rise) begin
        collision <= 1'b0;
      end else if (fg_op & sp_op & ~blank_in) begin
        collision <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pixel_render_pipeline.sv
// Scoreboard bench for pixel_render_pipeline.
// Stimulus pushes due-stamped expectations; a negedge monitor pops and compares.
module tb_pixel_render_pipeline;

  logic       video_clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] fg_color = '0;
  logic       fg_transparent = 1'b1;
  logic [7:0] sprite_color = '0;
  logic       sprite_transparent = 1'b1;
  logic [7:0] bg_color = '0;
  logic       bg_transparent = 1'b1;
  logic [2:0] layer_enable = '0;
  logic       hsync_in = 1'b0;
  logic       vsync_in = 1'b0;
  logic       blank_in = 1'b1;
  logic [9:0] palette_read_addr;
  logic [11:0] palette_read_data = '0;
  logic [3:0] red, green, blue;
  logic       hsync_out, vsync_out, blank_out, collision;

  pixel_render_pipeline dut (
    .video_clk(video_clk),
    .rst(rst),
    .fg_color(fg_color),
    .fg_transparent(fg_transparent),
    .sprite_color(sprite_color),
    .sprite_transparent(sprite_transparent),
    .bg_color(bg_color),
    .bg_transparent(bg_transparent),
    .layer_enable(layer_enable),
    .hsync_in(hsync_in),
    .vsync_in(vsync_in),
    .blank_in(blank_in),
    .palette_read_addr(palette_read_addr),
    .palette_read_data(palette_read_data),
    .red(red),
    .green(green),
    .blue(blue),
    .hsync_out(hsync_out),
    .vsync_out(vsync_out),
    .blank_out(blank_out),
    .collision(collision)
  );

  always #5 video_clk = ~video_clk;

  function automatic logic [11:0] pal(input logic [9:0] a);
    case (a)
      10'h025: pal = 12'hABC;
      10'h0FF: pal = 12'hFFF;
      default: pal = {2'b00, a} ^ 12'h5A5;
    endcase
  endfunction

  // synchronous palette PROM model
  always @(posedge video_clk) palette_read_data <= pal(palette_read_addr);

  typedef struct {
    int          due;
    logic [14:0] v;
  } item_t;

  item_t q_out[$];
  item_t q_addr[$];
  item_t q_col[$];

  int cyc = 0;
  int n_total = 0;
  int n_pass = 0;
  logic col_m = 1'b0;
  logic vprev_m = 1'b0;

  always @(posedge video_clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [14:0] act,
                       input logic [14:0] exp_v);
    n_total++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp_v);
  endtask

  task automatic service(inout item_t q[$], input string nm,
                         input logic [14:0] act);
    item_t it;
    while (q.size() > 0 && q[0].due <= cyc) begin
      it = q.pop_front();
      if (it.due < cyc) begin
        n_total++;
        $display("FAIL %s stale @cyc %0d: due %0d", nm, cyc, it.due);
      end else begin
        check(nm, act, it.v);
      end
    end
  endtask

  always @(negedge video_clk) begin
    service(q_out, "out",
            {red, green, blue, hsync_out, vsync_out, blank_out});
    service(q_addr, "addr", {5'd0, palette_read_addr});
    service(q_col, "collision", {14'd0, collision});
  end

  task automatic do_reset();
    @(posedge video_clk);
    #1;
    rst = 1'b1;
    q_out.delete();
    q_addr.delete();
    q_col.delete();
    col_m = 1'b0;
    vprev_m = 1'b0;
    for (int i = 1; i <= 3; i++) q_out.push_back('{cyc + i, 15'h0001});
    q_addr.push_back('{cyc + 1, 15'h0});
    q_col.push_back('{cyc + 1, 15'h0});
  endtask

  task automatic drive(input logic [2:0] le,
                       input logic [7:0] fc, input logic ft,
                       input logic [7:0] sc, input logic st,
                       input logic [7:0] bc, input logic bt,
                       input logic hs, input logic vs, input logic bl,
                       input logic [9:0] ea);
    logic [11:0] rgb;
    @(posedge video_clk);
    #1;
    rst = 1'b0;
    layer_enable = le;
    fg_color = fc;
    fg_transparent = ft;
    sprite_color = sc;
    sprite_transparent = st;
    bg_color = bc;
    bg_transparent = bt;
    hsync_in = hs;
    vsync_in = vs;
    blank_in = bl;
    if (vs && !vprev_m) col_m = 1'b0;
    else if (le[0] && !ft && le[1] && !st && !bl) col_m = 1'b1;
    vprev_m = vs;
    rgb = bl ? 12'h000 : pal(ea);
    q_out.push_back('{cyc + 3, {rgb, hs, vs, bl}});
    q_addr.push_back('{cyc + 1, {5'd0, ea}});
    q_col.push_back('{cyc + 1, {14'd0, col_m}});
  endtask

  initial begin
    repeat (2) @(posedge video_clk);
    do_reset();
    //     le      fc     ft  sc     st  bc     bt  hs vs bl addr
    drive(3'b111, 8'h25, 0, 8'h33, 0, 8'h44, 0, 0, 0, 0, 10'h025);
    drive(3'b111, 8'h25, 1, 8'h7F, 0, 8'h10, 0, 0, 0, 0, 10'h17F);
    drive(3'b111, 8'h25, 1, 8'h7F, 1, 8'h10, 0, 0, 0, 0, 10'h210);
    drive(3'b111, 8'h25, 1, 8'h7F, 1, 8'h10, 1, 0, 0, 0, 10'h300);
    drive(3'b000, 8'h25, 0, 8'h7F, 0, 8'h10, 0, 0, 0, 0, 10'h300);
    drive(3'b111, 8'h01, 0, 8'h02, 0, 8'h10, 0, 0, 1, 0, 10'h001);
    drive(3'b111, 8'h01, 0, 8'h02, 0, 8'h10, 0, 0, 1, 0, 10'h001);
    drive(3'b111, 8'hFF, 0, 8'h02, 1, 8'h10, 0, 1, 0, 1, 10'h0FF);
    drive(3'b111, 8'h00, 1, 8'h02, 1, 8'h66, 0, 1, 0, 1, 10'h266);
    drive(3'b111, 8'h03, 0, 8'h02, 1, 8'h10, 0, 0, 1, 0, 10'h003);
    drive(3'b111, 8'h03, 1, 8'h55, 0, 8'h10, 1, 0, 0, 0, 10'h155);
    drive(3'b111, 8'h04, 0, 8'h55, 0, 8'h10, 1, 1, 0, 0, 10'h004);
    do_reset();
    drive(3'b110, 8'h01, 0, 8'h02, 0, 8'h03, 0, 0, 0, 0, 10'h102);
    drive(3'b011, 8'h01, 1, 8'h7F, 0, 8'h10, 0, 0, 0, 0, 10'h17F);
    drive(3'b100, 8'h01, 0, 8'h02, 0, 8'h10, 0, 0, 0, 0, 10'h210);
    drive(3'b111, 8'h25, 0, 8'h33, 0, 8'h44, 0, 0, 0, 0, 10'h025);
    drive(3'b111, 8'h25, 0, 8'h33, 0, 8'h44, 0, 1, 0, 1, 10'h025);
    drive(3'b001, 8'h0A, 1, 8'h33, 0, 8'h44, 0, 0, 0, 0, 10'h300);
    drive(3'b111, 8'h0A, 0, 8'h33, 0, 8'h44, 0, 0, 1, 1, 10'h00A);
    repeat (6) @(posedge video_clk);
    #1;
    n_total++;
    if (q_out.size() == 0 && q_addr.size() == 0 && q_col.size() == 0)
      n_pass++;
    else
      $display("FAIL drain: left out=%0d addr=%0d col=%0d expected 0",
               q_out.size(), q_addr.size(), q_col.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
